// File: rtl/audio_mixer_pwm.sv
// Two-channel FIFO audio mixer with volume shift and 8-bit PWM output stage.
// Optional build macro UNDERRUN_MUTE_EN: a missed sample tick outputs mid-scale (0x80) instead of holding the last sample.
module audio_mixer_pwm #(
    parameter int SAMPLE_PERIOD = 2268,
    parameter int VOL_BITS      = 3
) (
    input  logic                clk_100mhz,
    input  logic                reset,
    input  logic [7:0]          ch0_data,
    input  logic                ch0_empty,
    output logic                ch0_rd,
    input  logic [7:0]          ch1_data,
    input  logic                ch1_empty,
    output logic                ch1_rd,
    input  logic                ch1_enable,
    input  logic [VOL_BITS-1:0] volume,
    output logic [7:0]          sample_out,
    output logic                sample_valid,
    output logic [15:0]         underrun_count,
    output logic                pwm_out
);

    localparam int          DATA_W    = 8;
    localparam logic [15:0] TICK_LAST = 16'(SAMPLE_PERIOD - 1);
    localparam logic [7:0]  MID_LEVEL = 8'h80;

    typedef enum logic [1:0] {IDLE, POP, CAPTURE, MIX} state_t;

    state_t              state, state_nxt;
    logic [15:0]         tick_cnt;
    logic                tick;
    logic                start;
    logic                underrun_tick;
    logic                en_p0;
    logic [VOL_BITS-1:0] vol_p0;
    logic [DATA_W-1:0]   ch0_p1, ch1_p1;
    logic [DATA_W-1:0]   mix_p2;
    logic [7:0]          pwm_cnt;
    logic [7:0]          pwm_level;

    function automatic logic [DATA_W-1:0] mix_pair(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic              en);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return en ? sum[DATA_W:1] : a;
    endfunction

    function automatic logic [DATA_W-1:0] attenuate(input logic [DATA_W-1:0] s,
                                                    input logic [VOL_BITS-1:0] sh);
        return s >> sh;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign tick          = (tick_cnt == TICK_LAST);
    assign start         = tick && !ch0_empty && (!ch1_enable || !ch1_empty);
    assign underrun_tick = (state == IDLE) && tick && !start;

    always_ff @(posedge clk_100mhz) begin
        if (reset || tick) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + 16'd1;
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = POP;
            POP:     state_nxt = CAPTURE;
            CAPTURE: state_nxt = MIX;
            MIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are combinational so the FIFO read lands in the tick cycle itself.
    always_comb begin
        ch0_rd = 1'b0;
        ch1_rd = 1'b0;
        if (!reset && state == IDLE && start) begin
            ch0_rd = 1'b1;
            ch1_rd = ch1_enable;
        end
    end

    // p0: mix controls frozen at the tick
    always_ff @(posedge clk_100mhz) begin
        if (state == IDLE && tick) begin
            en_p0  <= ch1_enable;
            vol_p0 <= volume;
        end
    end

    // p1: FIFO bytes, valid during POP
    always_ff @(posedge clk_100mhz) begin
        if (state == POP) begin
            ch0_p1 <= ch0_data;
            ch1_p1 <= ch1_data;
        end
    end

    // p2: mixed sample
    always_ff @(posedge clk_100mhz) begin
        if (state == CAPTURE) mix_p2 <= mix_pair(ch0_p1, ch1_p1, en_p0);
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            sample_out     <= MID_LEVEL;
            sample_valid   <= 1'b0;
            underrun_count <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (state == MIX) begin
                sample_out   <= attenuate(mix_p2, vol_p0);
                sample_valid <= 1'b1;
            end
            if (underrun_tick) begin
                underrun_count <= sat_inc(underrun_count);
`ifdef UNDERRUN_MUTE_EN
                sample_out     <= MID_LEVEL;
                sample_valid   <= 1'b1;
`else
                sample_out     <= sample_out;
`endif
            end
        end
    end

    // PWM level only reloads at the counter wrap so a period is never split.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            pwm_cnt   <= '0;
            pwm_level <= MID_LEVEL;
            pwm_out   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (pwm_cnt == 8'hFF) pwm_level <= sample_out;
            pwm_out <= (pwm_cnt < pwm_level);
        end
    end

endmodule

// File: tb/tb_audio_mixer_pwm.sv
// Directed bench for audio_mixer_pwm: mixing, volume, underrun, saturation, PWM duty and mid-sequence reset.
module tb_audio_mixer_pwm;

    logic        clk_100mhz = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  ch0_data = 8'hA5;
    logic        ch0_empty;
    logic        ch0_rd;
    logic [7:0]  ch1_data = 8'hA5;
    logic        ch1_empty;
    logic        ch1_rd;
    logic        ch1_enable = 1'b1;
    logic [2:0]  volume = 3'd0;
    logic [7:0]  sample_out;
    logic        sample_valid;
    logic [15:0] underrun_count;
    logic        pwm_out;

    audio_mixer_pwm dut (
        .clk_100mhz     (clk_100mhz),
        .reset          (reset),
        .ch0_data       (ch0_data),
        .ch0_empty      (ch0_empty),
        .ch0_rd         (ch0_rd),
        .ch1_data       (ch1_data),
        .ch1_empty      (ch1_empty),
        .ch1_rd         (ch1_rd),
        .ch1_enable     (ch1_enable),
        .volume         (volume),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid),
        .underrun_count (underrun_count),
        .pwm_out        (pwm_out)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO models: data is valid only in the cycle after a read strobe
    logic [7:0] mem0 [0:15];
    logic [7:0] mem1 [0:15];
    int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;
    int rd_err = 0;
    int vld_cnt = 0;
    int cyc = 0;

    assign ch0_empty = (wp0 == rp0);
    assign ch1_empty = (wp1 == rp1);

    always @(posedge clk_100mhz) begin
        if (ch0_rd) begin
            ch0_data <= mem0[rp0];
            rp0 <= rp0 + 1;
        end else begin
            ch0_data <= 8'hA5;
        end
        if (ch1_rd) begin
            ch1_data <= mem1[rp1];
            rp1 <= rp1 + 1;
        end else begin
            ch1_data <= 8'hA5;
        end
        if ((ch0_rd && ch0_empty) || (ch1_rd && ch1_empty)) rd_err <= rd_err + 1;
        if (sample_valid) vld_cnt <= vld_cnt + 1;
        cyc <= reset ? 0 : cyc + 1;
    end

    task automatic load0(input logic [7:0] v);
        mem0[wp0] = v;
        wp0++;
    endtask

    task automatic load1(input logic [7:0] v);
        mem1[wp1] = v;
        wp1++;
    endtask

    task automatic goto(input int n);
        int guard = 0;
        while (cyc < n && guard < 30000) begin
            @(negedge clk_100mhz);
            guard++;
        end
        chk("goto", cyc, n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk_100mhz);
        @(negedge clk_100mhz);
        reset = 1'b0;
    endtask

    task automatic window(input string tag, input int start_cyc, input int exp);
        int hi = 0;
        goto(start_cyc);
        repeat (256) begin
            if (pwm_out) hi++;
            @(negedge clk_100mhz);
        end
        chk(tag, hi, exp);
    endtask

    int vc;

    initial begin
        load0(8'h40); load0(8'hFF); load0(8'hFF);
        load1(8'hC0); load1(8'hFF); load1(8'h77);
        ch1_enable = 1'b1;
        volume     = 3'd0;
        do_reset();
        chk("rst_sample_out", sample_out, 8'h80);
        chk("rst_valid", sample_valid, 1'b0);
        chk("rst_rd", {ch0_rd, ch1_rd}, 2'b00);
        chk("rst_underrun", underrun_count, 16'h0);
        chk("rst_pwm", pwm_out, 1'b0);

        goto(2266); chk("rd_early", {ch0_rd, ch1_rd}, 2'b00);
        goto(2267); chk("rd_tick1", {ch0_rd, ch1_rd}, 2'b11);
        goto(2268); chk("rd_pulse", {ch0_rd, ch1_rd}, 2'b00);
        goto(2270); chk("valid_early", sample_valid, 1'b0);
        goto(2271); chk("valid_1", sample_valid, 1'b1);
        chk("mix_40_c0", sample_out, 8'h80);
        goto(2272); chk("valid_pulse", sample_valid, 1'b0);
        goto(4535); chk("rd_tick2", {ch0_rd, ch1_rd}, 2'b11);
        goto(4539); chk("valid_2", sample_valid, 1'b1);
        chk("mix_ff_ff", sample_out, 8'hFF);

        goto(4540); ch1_enable = 1'b0; volume = 3'd2;
        goto(6803); chk("rd_ch0_only", {ch0_rd, ch1_rd}, 2'b10);
        goto(6804); ch1_enable = 1'b1; volume = 3'd0;
        goto(6807); chk("valid_3", sample_valid, 1'b1);
        chk("vol2_ff", sample_out, 8'h3F);
        chk("ch1_pops", rp1, 2);

        goto(6808); vc = vld_cnt;
        goto(9071); chk("rd_underrun", {ch0_rd, ch1_rd}, 2'b00);
        goto(13609);
        chk("underrun_3", underrun_count, 16'd3);
`ifdef UNDERRUN_MUTE_EN
        chk("underrun_out", sample_out, 8'h80);
        chk("underrun_vld", vld_cnt - vc, 3);
`else
        chk("underrun_out", sample_out, 8'h3F);
        chk("underrun_vld", vld_cnt - vc, 0);
`endif
        chk("pops_after_underrun", {rp0[7:0], rp1[7:0]}, {8'd3, 8'd2});

        force dut.underrun_count = 16'hFFFE;
        #1;
        release dut.underrun_count;
        goto(15876); chk("sat_first", underrun_count, 16'hFFFF);
        goto(20412); chk("sat_hold", underrun_count, 16'hFFFF);
        chk("rd_on_empty", rd_err, 0);

        load0(8'h00); load0(8'hFF); load0(8'h80);
        ch1_enable = 1'b0;
        volume     = 3'd0;
        do_reset();
        chk("rst2_sample_out", sample_out, 8'h80);
        chk("rst2_underrun", underrun_count, 16'h0);
        window("pwm_rst_level", 1, 128);
        window("pwm_before_00", 2049, 128);
        chk("sample_00", sample_out, 8'h00);
        window("pwm_00", 2305, 0);
        window("pwm_before_ff", 4353, 0);
        chk("sample_ff", sample_out, 8'hFF);
        window("pwm_ff", 4609, 255);
        window("pwm_before_80", 6657, 255);
        chk("sample_80", sample_out, 8'h80);
        window("pwm_80", 6913, 128);

        load0(8'h10); load0(8'h22);
        goto(9071); chk("rd_before_abort", ch0_rd, 1'b1);
        goto(9073);
        vc = vld_cnt;
        reset = 1'b1;
        @(negedge clk_100mhz);
        chk("abort_valid", sample_valid, 1'b0);
        chk("abort_sample_out", sample_out, 8'h80);
        chk("abort_rd", {ch0_rd, ch1_rd}, 2'b00);
        chk("abort_pwm", pwm_out, 1'b0);
        chk("abort_underrun", underrun_count, 16'h0);
        reset = 1'b0;
        goto(2266);
        chk("abort_no_vld", vld_cnt - vc, 0);
        chk("abort_rd_early", ch0_rd, 1'b0);
        goto(2267); chk("abort_rd_tick", ch0_rd, 1'b1);
        goto(2271); chk("abort_next_valid", sample_valid, 1'b1);
        chk("abort_next_sample", sample_out, 8'h22);
        chk("rd_on_empty_end", rd_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
